// File: rtl/nibble_serial_add.sv
// Nibble-serial adder: drives an external 4-bit full adder one nibble per cycle, LSB first.
// Define NIBBLE_SERIAL_OVF_EN to add the signed-overflow output ovf.
module nibble_serial_add #(
    parameter int unsigned N_NIB = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [4*N_NIB-1:0]   a,
    input  logic [4*N_NIB-1:0]   b,
    input  logic                 c_in,
    output logic                 busy,
    output logic                 done,
    output logic [4*N_NIB-1:0]   sum,
    output logic                 c_out,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout
`ifdef NIBBLE_SERIAL_OVF_EN
    ,
    output logic                 ovf
`endif
);

    localparam int unsigned W    = 4 * N_NIB;
    localparam int unsigned IdxW = (N_NIB > 1) ? $clog2(N_NIB) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_NIB - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            c_out_q, c_out_d;
`ifdef NIBBLE_SERIAL_OVF_EN
    logic            ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
`ifdef NIBBLE_SERIAL_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    idx_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                sum_d[4*idx_q +: 4] = add_sum;
                carry_d             = add_cout;
                idx_d               = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    c_out_d = add_cout;
                    state_d = StDone;
`ifdef NIBBLE_SERIAL_OVF_EN
                    // add_sum[3] is the result MSB since the top nibble is captured last
                    ovf_d = (a_q[W-1] == b_q[W-1]) && (add_sum[3] != a_q[W-1]);
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
`ifdef NIBBLE_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
`ifdef NIBBLE_SERIAL_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        busy    = (state_q == StRun);
        done    = (state_q == StDone);
        sum     = sum_q;
        c_out   = c_out_q;
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        if (busy) begin
            add_a   = a_q[4*idx_q +: 4];
            add_b   = b_q[4*idx_q +: 4];
            add_cin = carry_q;
        end
    end

`ifdef NIBBLE_SERIAL_OVF_EN
    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_add.sv
// Scoreboard bench for nibble_serial_add: driver pushes arithmetic expectations, negedge monitor
// pops them on done. External 4-bit adder is modelled here; honours NIBBLE_SERIAL_OVF_EN.
module tb_nibble_serial_add;

    localparam int unsigned N_NIB = 4;
    localparam int unsigned W     = 4 * N_NIB;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a, b;
    logic         c_in;
    logic         busy, done;
    logic [W-1:0] sum;
    logic         c_out;
    logic [3:0]   add_a, add_b;
    logic         add_cin;
    logic [3:0]   add_sum;
    logic         add_cout;
`ifdef NIBBLE_SERIAL_OVF_EN
    logic         ovf;
`endif

    nibble_serial_add #(.N_NIB(N_NIB)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
`ifdef NIBBLE_SERIAL_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;   // cyc value right after the accepting edge
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Called at posedge+#1; start is sampled at the following edge.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        exp_t         e;
        logic [W:0]   full;
        bit           acc_ok;
        acc_ok = 1'b1;
        if (q.size() > 0) begin
            if (cyc >= q[q.size()-1].acc && cyc < q[q.size()-1].acc + int'(N_NIB)) acc_ok = 1'b0;
        end
        a = ta; b = tb; c_in = tc; start = 1'b1;
        if (acc_ok) begin
            full   = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
            e.sum  = full[W-1:0];
            e.cout = full[W];
            e.ovf  = (ta[W-1] == tb[W-1]) && (full[W-1] != ta[W-1]);
            e.acc  = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
        a     = W'($urandom());
        b     = W'($urandom());
        c_in  = 1'($urandom());
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sum"}, 32'(sum), 32'h0);
        check({tag, "_cout"}, 32'(c_out), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_addport"}, {23'h0, add_a, add_b, add_cin}, 32'h0);
`ifdef NIBBLE_SERIAL_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'h0);
`endif
    endtask

    // Monitor: busy from model occupancy, idle adder ports, done timing and result.
    always @(negedge clk) begin
        bit exp_busy;
        if (!reset) begin
            exp_busy = 1'b0;
            if (q.size() > 0) exp_busy = (cyc >= q[0].acc) && (cyc < q[0].acc + int'(N_NIB));
            check("busy", 32'(busy), 32'(exp_busy));
            if (!busy) check("idle_addport", {23'h0, add_a, add_b, add_cin}, 32'h0);
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'h0);
                end else begin
                    check("done_latency", 32'(cyc), 32'(q[0].acc + int'(N_NIB)));
                    check("sum", 32'(sum), 32'(q[0].sum));
                    check("c_out", 32'(c_out), 32'(q[0].cout));
`ifdef NIBBLE_SERIAL_OVF_EN
                    check("ovf", 32'(ovf), 32'(q[0].ovf));
`endif
                    void'(q.pop_front());
                end
            end else if (q.size() > 0 && cyc >= q[0].acc + int'(N_NIB)) begin
                check("missing_done", 32'(done), 32'h1);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // First start at the first edge after reset release.
        send(16'h1234, 16'h4321, 1'b0); idle(N_NIB + 1);
        send(16'hFFFF, 16'h0001, 1'b0); idle(N_NIB + 1);
        send(16'h0009, 16'h0009, 1'b1); idle(N_NIB + 1);
        send(16'hA00A, 16'hF005, 1'b1); idle(N_NIB + 1);
        send(16'h7FFF, 16'h0001, 1'b0); idle(N_NIB + 1);
        send(16'h8000, 16'h8000, 1'b0); idle(N_NIB + 1);

        // Start during RUN is ignored; start in the DONE cycle is accepted.
        send(16'h1111, 16'h1111, 1'b0);
        acc0 = cyc;
        idle(1);
        send(16'hFFFF, 16'hFFFF, 1'b1);
        idle(acc0 + int'(N_NIB) - cyc);
        send(16'h2468, 16'h1357, 1'b1);
        idle(N_NIB + 2);

        // Reset in mid-RUN: outputs clear immediately, no done follows.
        send(16'h5A5A, 16'hA5A5, 1'b1);
        idle(1);
        reset = 1'b1;
        q.delete();
        #1;
        check_all_zero("mid_run_reset");
        idle(2);
        reset = 1'b0;
        send(16'h0F0F, 16'h00F1, 1'b0);
        idle(N_NIB + 2);

        for (int i = 0; i < 40; i++) begin
            idle(int'($urandom_range(0, 6)));
            send(W'($urandom()), W'($urandom()), 1'($urandom()));
        end
        idle(N_NIB + 3);
        check("queue_drained", 32'(q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add.md
NIBBLE_SERIAL_ADD -- requirements
Module: nibble_serial_add

Interface
REQ-001 SHALL have parameter N_NIB, default 4, number of 4-bit nibbles per operand; operand width W = 4*N_NIB.
REQ-002 SHALL have one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port start  input  1  request to add a, b and c_in.
REQ-006 SHALL have port a  input  W  operand A.
REQ-007 SHALL have port b  input  W  operand B.
REQ-008 SHALL have port c_in  input  1  carry-in.
REQ-009 SHALL have port busy  output  1  high while the operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when the result is valid.
REQ-011 SHALL have port sum  output  W  result.
REQ-012 SHALL have port c_out  output  1  final carry-out.
REQ-013 SHALL have port add_a  output  4  nibble of A driven to the external 4-bit full adder.
REQ-014 SHALL have port add_b  output  4  nibble of B driven to the external adder.
REQ-015 SHALL have port add_cin  output  1  carry driven to the external adder.
REQ-016 SHALL have port add_sum  input  4  sum returned by the external adder (combinational).
REQ-017 SHALL have port add_cout  input  1  carry returned by the external adder (combinational).

Function
REQ-018 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-019 In IDLE or DONE, start=1 at a clock edge SHALL latch a, b and c_in into internal registers, clear the nibble index to 0 and enter RUN.
REQ-020 In RUN, add_a/add_b SHALL be latched nibble[idx] of A/B, and add_cin SHALL be the carry register (latched c_in at idx=0).
REQ-021 In RUN, each edge SHALL write add_sum into sum[4*idx+3:4*idx], load the carry register with add_cout and increment idx.
REQ-022 When idx=N_NIB-1 is captured, the block SHALL enter DONE, with c_out equal to the final add_cout.
REQ-023 done SHALL be 1 for exactly the single DONE cycle; the FSM SHALL return to IDLE next unless start=1 (back-to-back accepted).
REQ-024 Latency: done SHALL be high N_NIB+1 cycles after the edge sampling start (5 cycles for N_NIB=4).
REQ-025 busy SHALL be 1 exactly while in RUN.
REQ-026 start during RUN SHALL be ignored, with operands unchanged.
REQ-027 sum and c_out SHALL hold their values after DONE until the next accepted start; partial sum during RUN is unspecified to users.
REQ-028 In IDLE and DONE, add_a, add_b and add_cin SHALL be driven to 0.
REQ-029 Input changes to a, b and c_in after acceptance SHALL NOT affect the result.

Reset
REQ-030 reset=1 SHALL asynchronously force IDLE, with idx, carry register, operand registers, sum, c_out, busy, done and ovf (if present) all at 0.
REQ-031 reset asserted during RUN SHALL abort the operation without producing a done pulse.
REQ-032 The first start SHALL be accepted at the first edge after reset deasserts.

Configuration
REQ-033 With macro NIBBLE_SERIAL_OVF_EN defined, the block SHALL add output ovf (1 bit), set in DONE to the signed two's-complement overflow (A[W-1]==B[W-1] and sum[W-1]!=A[W-1]) and held like sum.
REQ-034 Without NIBBLE_SERIAL_OVF_EN, the ovf port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-035 a=0x1234, b=0x4321, c_in=0, start pulse -> done 5 cycles later with sum=0x5555, c_out=0, busy high for 4 cycles.
REQ-036 a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1 (carry ripples through all nibbles).
REQ-037 a=0x0009, b=0x0009, c_in=1 -> sum=0x0013, c_out=0; a=0xA00A, b=0xF005, c_in=1 -> sum=0x9010, c_out=1.
REQ-038 With NIBBLE_SERIAL_OVF_EN, a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1; a=0x8000, b=0x8000 -> sum=0x0000, c_out=1, ovf=1.
REQ-039 start with 0x1111+0x1111, then start at RUN cycle 2 with 0xFFFF+0xFFFF -> single done, sum=0x2222; back-to-back start in the DONE cycle is accepted and the next done comes 5 cycles later.
REQ-040 reset pulsed at RUN cycle 2 -> no done, and all outputs are 0 immediately, without waiting for a clock edge.
